// File: rtl/rt_frame_pkg.sv
// rtl/rt_frame_pkg.sv - shared FSM states, status bits and trailer layout for rt_frame_packer
package rt_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_TRAILER = 2'd2
    } state_e;

    localparam int STAT_LEN_ERR  = 0;
    localparam int STAT_SYNC_ERR = 1;
    localparam int STAT_OVERFLOW = 2;

    localparam int TRL_CNT_LSB  = 0;
    localparam int TRL_STAT_LSB = 8;
    localparam int TRL_SEQ_LSB  = 16;

    function automatic logic [31:0] pack_trailer(input logic [15:0] seq,
                                                 input logic [7:0]  status,
                                                 input logic [7:0]  cnt);
        logic [31:0] w;
        w = '0;
        w[TRL_SEQ_LSB +: 16] = seq;
        w[TRL_STAT_LSB +: 8] = status;
        w[TRL_CNT_LSB +: 8]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/rt_frame_fifo.sv
// rtl/rt_frame_fifo.sv - synchronous FIFO holding {last, data}; full is judged before a same-cycle read
module rt_frame_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    // Head word is gated so the output reads zero whenever nothing is presented.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/rt_frame_packer.sv
// rtl/rt_frame_packer.sv - frames RT payload bursts with a status trailer into an output FIFO
// Define RT_FRAME_CHECKSUM_EN to emit an XOR checksum word ahead of each trailer.
module rt_frame_packer
    import rt_frame_pkg::*;
#(
    parameter int FRAME_WORDS = 43,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic        processing_clock,
    input  logic        PCIe_trn_rst_n,
    input  logic        in_wr_en,
    input  logic [31:0] in_wr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [15:0] frame_count,
    output logic [15:0] err_len_count,
    output logic [15:0] err_sync_count,
    output logic        overflow
);
    state_e      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [31:0] first_q, first_d;
    logic [31:0] last_q, last_d;
    logic        frame_ovf_q, frame_ovf_d;
    logic        pend_ovf_q, pend_ovf_d;
    logic        overflow_q, overflow_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_len_q, err_len_d;
    logic [15:0] err_sync_q, err_sync_d;
`ifdef RT_FRAME_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;
    logic        cks_done_q, cks_done_d;
`endif

    logic        fifo_wr, fifo_full, fifo_empty, close;
    logic [32:0] fifo_wdata, fifo_rdata;
    logic        len_err, sync_err;
    logic [7:0]  status;

    assign len_err  = (int'(word_cnt_q) != FRAME_WORDS);
    assign sync_err = (first_q != last_q);

    always_comb begin
        status                = '0;
        status[STAT_LEN_ERR]  = len_err;
        status[STAT_SYNC_ERR] = sync_err;
        status[STAT_OVERFLOW] = frame_ovf_q;
    end

    always_ff @(posedge processing_clock or negedge PCIe_trn_rst_n) begin
        if (!PCIe_trn_rst_n) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            first_q     <= '0;
            last_q      <= '0;
            frame_ovf_q <= 1'b0;
            pend_ovf_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_len_q   <= '0;
            err_sync_q  <= '0;
`ifdef RT_FRAME_CHECKSUM_EN
            cks_q       <= '0;
            cks_done_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            first_q     <= first_d;
            last_q      <= last_d;
            frame_ovf_q <= frame_ovf_d;
            pend_ovf_q  <= pend_ovf_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            err_sync_q  <= err_sync_d;
`ifdef RT_FRAME_CHECKSUM_EN
            cks_q       <= cks_d;
            cks_done_q  <= cks_done_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        first_d     = first_q;
        last_d      = last_q;
        frame_ovf_d = frame_ovf_q;
        pend_ovf_d  = pend_ovf_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        err_len_d   = err_len_q;
        err_sync_d  = err_sync_q;
`ifdef RT_FRAME_CHECKSUM_EN
        cks_d       = cks_q;
        cks_done_d  = cks_done_q;
`endif
        fifo_wr     = 1'b0;
        fifo_wdata  = '0;
        close       = 1'b0;

        unique case (state_q)
            ST_IDLE: if (in_wr_en) begin
                state_d     = ST_COLLECT;
                first_d     = in_wr_data;
                word_cnt_d  = '0;
                frame_ovf_d = pend_ovf_q;
                pend_ovf_d  = 1'b0;
`ifdef RT_FRAME_CHECKSUM_EN
                cks_d       = '0;
`endif
            end
            ST_COLLECT: if (!in_wr_en) state_d = ST_TRAILER;
            ST_TRAILER: begin
                // Words landing here belong to no open frame; charge them to the next one.
                if (in_wr_en) begin
                    pend_ovf_d = 1'b1;
                    overflow_d = 1'b1;
                end
                if (!fifo_full) begin
`ifdef RT_FRAME_CHECKSUM_EN
                    if (!cks_done_q) begin
                        fifo_wr    = 1'b1;
                        fifo_wdata = {1'b0, cks_q};
                        cks_done_d = 1'b1;
                    end else begin
                        close      = 1'b1;
                        cks_done_d = 1'b0;
                    end
`else
                    close = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_wr_en && state_q != ST_TRAILER) begin
            last_d = in_wr_data;
            if (fifo_full) begin
                frame_ovf_d = 1'b1;
                overflow_d  = 1'b1;
            end else begin
                fifo_wr    = 1'b1;
                fifo_wdata = {1'b0, in_wr_data};
                if (word_cnt_d != 8'hFF) word_cnt_d = word_cnt_d + 8'd1;
`ifdef RT_FRAME_CHECKSUM_EN
                cks_d = cks_d ^ in_wr_data;
`endif
            end
        end

        if (close) begin
            fifo_wr     = 1'b1;
            fifo_wdata  = {1'b1, pack_trailer(frame_cnt_q, status, word_cnt_q)};
            frame_cnt_d = frame_cnt_q + 16'd1;
            err_len_d   = err_len_q + {15'd0, len_err};
            err_sync_d  = err_sync_q + {15'd0, sync_err};
            state_d     = ST_IDLE;
        end
    end

    rt_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk_i     (processing_clock),
        .rst_n_i   (PCIe_trn_rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (out_ready),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign out_valid      = !fifo_empty;
    assign out_data       = fifo_rdata[31:0];
    assign out_last       = fifo_rdata[32];
    assign frame_count    = frame_cnt_q;
    assign err_len_count  = err_len_q;
    assign err_sync_count = err_sync_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_rt_frame_packer.sv
// tb/tb_rt_frame_packer.sv - self-checking bench for rt_frame_packer with a 4-entry output FIFO
module tb_rt_frame_packer;
    localparam int FW    = 43;
    localparam int DEPTH = 4;
`ifdef RT_FRAME_CHECKSUM_EN
    localparam int CKS = 1;
`else
    localparam int CKS = 0;
`endif
    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_TRAILER = 2;

    typedef struct {
        int          n;
        logic [31:0] base;
        logic [31:0] fin;
        logic [31:0] exp_trl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_wr_en = 1'b0;
    logic [31:0] in_wr_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [15:0] frame_count;
    logic [15:0] err_len_count;
    logic [15:0] err_sync_count;
    logic        overflow;

    always #5 clk = ~clk;

    rt_frame_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
        .processing_clock (clk),
        .PCIe_trn_rst_n   (rst_n),
        .in_wr_en         (in_wr_en),
        .in_wr_data       (in_wr_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .frame_count      (frame_count),
        .err_len_count    (err_len_count),
        .err_sync_count   (err_sync_count),
        .overflow         (overflow)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [32:0] mq[$];
    logic [32:0] got_q[$];
    int          m_phase;
    int          m_cnt;
    logic [31:0] m_first, m_last, m_cks;
    logic        m_fovf, m_pend, m_sticky, m_cks_done;
    logic [15:0] m_seq, m_el, m_es;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_phase = P_IDLE; m_cnt = 0;
        m_first = '0; m_last = '0; m_cks = '0;
        m_fovf = 1'b0; m_pend = 1'b0; m_sticky = 1'b0; m_cks_done = 1'b0;
        m_seq = '0; m_el = '0; m_es = '0;
    endtask

    // One clock edge of the reference: queue mq is the expected buffer content.
    task automatic m_step(input logic wr, input logic [31:0] d, input logic rdy);
        logic full, len, sync;
        full = (mq.size() == DEPTH);
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (m_phase == P_TRAILER) begin
            if (wr) begin m_pend = 1'b1; m_sticky = 1'b1; end
            if (!full) begin
                if (CKS != 0 && !m_cks_done) begin
                    mq.push_back({1'b0, m_cks});
                    m_cks_done = 1'b1;
                end else begin
                    len  = (m_cnt != FW);
                    sync = (m_first != m_last);
                    mq.push_back({1'b1, m_seq, 5'd0, m_fovf, sync, len, 8'(m_cnt)});
                    m_seq = m_seq + 16'd1;
                    m_el  = m_el + 16'(len);
                    m_es  = m_es + 16'(sync);
                    m_phase = P_IDLE;
                    m_cks_done = 1'b0;
                end
            end
        end else if (wr) begin
            if (m_phase == P_IDLE) begin
                m_phase = P_COLLECT; m_first = d; m_cnt = 0;
                m_fovf = m_pend; m_pend = 1'b0; m_cks = '0;
            end
            m_last = d;
            if (full) begin
                m_fovf = 1'b1; m_sticky = 1'b1;
            end else begin
                mq.push_back({1'b0, d});
                if (m_cnt < 255) m_cnt++;
                m_cks = m_cks ^ d;
            end
        end else if (m_phase == P_COLLECT) begin
            m_phase = P_TRAILER;
        end
    endtask

    task automatic chk_out();
        if (mq.size() > 0)
            chk("out_word", 64'({out_valid, out_last, out_data}), 64'({1'b1, mq[0]}));
        else
            chk("out_valid", 64'(out_valid), 64'd0);
        chk("counters", 64'({frame_count, err_len_count, err_sync_count, overflow}),
            64'({m_seq, m_el, m_es, m_sticky}));
    endtask

    task automatic cycle(input logic wr, input logic [31:0] d, input logic rdy);
        in_wr_en = wr; in_wr_data = d; out_ready = rdy;
        if (out_valid && rdy) got_q.push_back({out_last, out_data});
        @(posedge clk);
        m_step(wr, d, rdy);
        @(negedge clk);
        chk_out();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_wr_en = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_flags", 64'({out_valid, out_last, overflow}), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_counters", 64'({frame_count, err_len_count, err_sync_count}), 64'd0);
        m_reset();
        got_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic send_frame(input int n, input logic [31:0] base, input logic [31:0] fin, input int mode);
        for (int i = 0; i < n; i++)
            cycle(1'b1, (i == n - 1) ? fin : base + 32'(i), pick_rdy(mode));
    endtask

    function automatic int count_last();
        int c = 0;
        foreach (got_q[i]) if (got_q[i][32]) c++;
        return c;
    endfunction

    function automatic int last_idx(input int k);
        int c = 0;
        foreach (got_q[i]) begin
            if (got_q[i][32]) begin
                if (c == k) return i;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [32:0] got_at(input int i);
        if (i >= 0 && i < got_q.size()) return got_q[i];
        return '1;
    endfunction

    task automatic drain_until(input int nlast, input int limit, input string name);
        int cyc = 0;
        while (count_last() < nlast && cyc < limit) begin
            cycle(1'b0, 32'd0, 1'b1);
            cyc++;
        end
        chk(name, 64'(count_last() >= nlast), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        int   ti;
        tbl[0] = '{43,  32'h100,  32'h100,  32'h0000_002B};
        tbl[1] = '{40,  32'h300,  32'h300,  32'h0001_0128};
        tbl[2] = '{43,  32'h500,  32'hDEAD, 32'h0002_022B};
        tbl[3] = '{1,   32'h77,   32'h77,   32'h0003_0101};
        tbl[4] = '{300, 32'h1000, 32'h1000, 32'h0004_01FF};

        #2;
        do_reset();

        for (int t = 0; t < 5; t++) begin
            got_q.delete();
            send_frame(tbl[t].n, tbl[t].base, tbl[t].fin, 1);
            cycle(1'b0, 32'd0, 1'b1);
            drain_until(1, 20, "tbl_drain_done");
            ti = last_idx(0);
            chk("tbl_trailer", 64'(got_at(ti)), 64'({1'b1, tbl[t].exp_trl}));
            chk("tbl_payload_cnt", 64'(ti), 64'(tbl[t].n + CKS));
        end
        chk("tbl_frame_count", 64'(frame_count), 64'd5);
        chk("tbl_err_len", 64'(err_len_count), 64'd3);
        chk("tbl_err_sync", 64'(err_sync_count), 64'd1);
        chk("tbl_overflow", 64'(overflow), 64'd0);

        // Consumer stalled: four words fit, the rest drop, the trailer waits for space.
        got_q.delete();
        send_frame(43, 32'h200, 32'h200, 0);
        repeat (5) cycle(1'b0, 32'd0, 1'b0);
        chk("hold_overflow", 64'(overflow), 64'd1);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_frame_count", 64'(frame_count), 64'd5);
        drain_until(1, 30, "hold_drain_done");
        ti = last_idx(0);
        for (int i = 0; i < 4; i++)
            chk("hold_payload", 64'(got_at(i)), 64'({1'b0, 32'h200 + 32'(i)}));
        chk("hold_trailer", 64'(got_at(ti)), 64'({1'b1, 32'h0005_0504}));
        chk("hold_payload_cnt", 64'(ti), 64'(4 + CKS));
        chk("hold_err_len", 64'(err_len_count), 64'd4);

        // Reset in the middle of a frame.
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b1);
        do_reset();
        send_frame(43, 32'h600, 32'h600, 1);
        cycle(1'b0, 32'd0, 1'b1);
        drain_until(1, 20, "post_reset_drain_done");
        chk("post_reset_trailer", 64'(got_at(last_idx(0))), 64'({1'b1, 32'h0000_002B}));
        chk("post_reset_frame_count", 64'(frame_count), 64'd1);

        // Short frame, then a stray word while the trailer is being written.
        do_reset();
        send_frame(3, 32'h1, 32'h1, 1);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'hBAD, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        send_frame(1, 32'h7, 32'h7, 1);
        cycle(1'b0, 32'd0, 1'b1);
        drain_until(2, 20, "discard_drain_done");
        ti = last_idx(0);
        chk("short_trailer", 64'(got_at(ti)), 64'({1'b1, 32'h0000_0103}));
        chk("short_payload_cnt", 64'(ti), 64'(3 + CKS));
        chk("pre_trailer_word", 64'(got_at(ti - 1)), 64'({1'b0, (CKS != 0) ? 32'h2 : 32'h1}));
        chk("discard_trailer", 64'(got_at(last_idx(1))), 64'({1'b1, 32'h0001_0501}));
        chk("discard_overflow", 64'(overflow), 64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int f = 0; f < 60; f++) begin
            int          n, gap, rm;
            logic [31:0] b, fin;
            n   = ($urandom_range(0, 3) == 0) ? FW : int'($urandom_range(1, 50));
            b   = $urandom;
            fin = ($urandom_range(0, 1) == 1) ? b : $urandom;
            rm  = $urandom_range(1, 3);
            send_frame(n, b, fin, rm);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cycle(1'b0, 32'd0, pick_rdy(rm));
        end
        repeat (40) cycle(1'b0, 32'd0, 1'b1);
        chk("rand_drained", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rt_frame_packer.md
RT_FRAME_PACKER -- requirements
Module: rt_frame_packer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 43, expected payload words per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, output buffer depth in entries, power of two, >= 4.
REQ-003 SHALL have port processing_clock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port PCIe_trn_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port in_wr_en  in  1  payload strobe from the RT word serializer.
REQ-006 SHALL have port in_wr_data  in  32  payload word, valid when in_wr_en=1.
REQ-007 SHALL have port out_valid  out  1  output word available.
REQ-008 SHALL have port out_ready  in  1  DMA consumer accepts word when out_valid&out_ready.
REQ-009 SHALL have port out_data  out  32  output word.
REQ-010 SHALL have port out_last  out  1  marks the trailer word of a frame.
REQ-011 SHALL have port frame_count  out  16  frames closed since reset.
REQ-012 SHALL have port err_len_count  out  16  frames with length error.
REQ-013 SHALL have port err_sync_count  out  16  frames with sync error.
REQ-014 SHALL have port overflow  out  1  sticky, set on any dropped word.

Function
REQ-015 SHALL implement FSM IDLE, COLLECT, TRAILER; IDLE->COLLECT on in_wr_en=1; COLLECT->TRAILER on first cycle with in_wr_en=0; TRAILER->IDLE when the trailer is written.
REQ-016 SHALL write each accepted payload word into the FIFO with last=0 at the edge sampling in_wr_en=1; word_cnt (8-bit) increments, saturating at 255.
REQ-017 SHALL capture the first word of each frame and compare it with the last word at frame close; mismatch sets sync error (serializer repeats word0 as final word).
REQ-018 SHALL flag length error when word_cnt != FRAME_WORDS.
REQ-019 SHALL write trailer {frame_seq[15:0], status[7:0], word_cnt[7:0]} with last=1; status bit0=length error, bit1=sync error, bit2=overflow in frame, bits7:3=0.
REQ-020 SHALL, in TRAILER with FIFO full, hold the trailer until space exists; payload words arriving while in TRAILER are discarded and set bit2 of the next frame's status.
REQ-021 SHALL drop a payload word arriving when FIFO is full (full evaluated before a same-cycle read), set status bit2 and overflow; drops do not increment word_cnt.
REQ-022 SHALL increment frame_seq, frame_count and relevant error counters once per trailer write; all 16-bit counters wrap 0xFFFF->0.
REQ-023 SHALL present a word on out_valid/out_data/out_last the cycle after it is written into an empty FIFO; out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL treat a single-cycle frame (one word) normally: word_cnt=1, sync compare of word against itself passes.

Reset
REQ-025 SHALL on PCIe_trn_rst_n=0 force state IDLE, FIFO empty, out_valid=0, out_data=0, out_last=0, all counters 0, frame_seq 0, overflow 0.
REQ-026 SHALL on reset mid-frame discard the partial frame with no trailer; first frame after release starts at frame_seq 0.

Configuration
REQ-027 SHALL, with macro RT_FRAME_CHECKSUM_EN defined, write an extra word (XOR of all accepted payload words, last=0) immediately before the trailer; word_cnt excludes it.
REQ-028 SHALL, without RT_FRAME_CHECKSUM_EN, emit only payload plus trailer and contain no checksum logic.

Structure
REQ-029 SHALL place FSM state enum, status bit indices and trailer field offsets in shared package rt_frame_pkg.
REQ-030 SHALL instantiate one sub-module rt_frame_fifo (synchronous 33-bit FIFO, data+last, full/empty flags).

Verification
REQ-031 SHALL cover: 43 words 0x100..0x12A then word 42 = 0x100, out_ready=1 -> 43 payload words, trailer 0x0000_002B, frame_count=1.
REQ-032 SHALL cover: 40-word frame, first/last equal -> trailer status=0x01, word_cnt=0x28, err_len_count=1.
REQ-033 SHALL cover: 43 words, last=0xDEAD != first -> trailer status=0x02, err_sync_count=1.
REQ-034 SHALL cover: FIFO_DEPTH=4, out_ready=0, 43-word frame -> 4 words buffered, overflow=1, trailer held; release out_ready -> trailer status bit2=1, word_cnt=4.
REQ-035 SHALL cover: reset asserted after 20 words -> out_valid=0, counters 0; next full frame yields trailer frame_seq=0.
REQ-036 SHALL cover: with RT_FRAME_CHECKSUM_EN, frame 0x1,0x2,0x1 -> checksum word 0x2 precedes trailer 0x0000_0103.
